add_rca_pipe: RTL

- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's fixed 16-bit combinational ripple adder.
- Operand width is split into SEG-bit segments. Each segment is one pipeline stage, and the carry is registered between stages.
- A valid/ready stream interface sits on both sides, with full backpressure.
- Sits in the datapath wherever a wide add has to close timing at clock rate.

---
 rtl/add_pkg.sv | 16 +
 rtl/add_rca_pipe_if.sv | 26 ++
 rtl/add_rca_seg.sv | 26 ++
 rtl/add_rca_pipe.sv | 114 +++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry adder.
package add_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned stages(input int unsigned width, input int unsigned seg);
    return (seg == 0) ? 1 : width / seg;
  endfunction

  // Legal only when the operand splits into whole segments.
  function automatic bit seg_ok(input int unsigned width, input int unsigned seg);
    return (width >= 1) && (seg >= 1) && (seg <= width) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/add_rca_pipe_if.sv
// Operand/result stream bundle for add_rca_pipe, valid/ready on both sides.
interface add_rca_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/add_rca_seg.sv
// Combinational SEG-bit ripple of full adders; also exposes the carry into the top bit.
module add_rca_seg #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] sum,
  output logic           c_out,
  output logic           c_msb_in
);
  localparam int N = int'(SEG);

  always_comb begin : ripple
    logic cy;
    cy       = c_in;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) c_msb_in = cy;
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end
endmodule

// File: rtl/add_rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage,
// carry and partial sum registered between stages, full valid/ready backpressure.
module add_rca_pipe
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input logic          clk,
  input logic          rst_n,
  add_rca_pipe_if.slave bus
);
  localparam int unsigned STAGES = stages(WIDTH, SEG);
  localparam int          NS     = int'(STAGES);

  if (!seg_ok(WIDTH, SEG)) begin : g_bad_seg
    $error("add_rca_pipe: WIDTH must be a nonzero multiple of SEG");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] cy_q;
  logic              ovf_q;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  ps_q  [STAGES];

  logic [WIDTH-1:0]  sa     [STAGES];
  logic [WIDTH-1:0]  sb     [STAGES];
  logic [WIDTH-1:0]  sps    [STAGES];
  logic [WIDTH-1:0]  ps_nxt [STAGES];
  logic [SEG-1:0]    seg_sum[STAGES];
  logic              seg_cm [STAGES];
  logic [STAGES-1:0] scy;
  logic [STAGES-1:0] sv;
  logic [STAGES-1:0] seg_co;
  logic [WIDTH-1:0]  b_eff;

  assign b_eff = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;

  // Ready ripples back from the output; an empty stage frees every stage behind it.
  always_comb begin : ready_chain
    logic r;
    r    = bus.out_ready;
    load = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      r       = !v[k] || r;
      load[k] = r;
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SEG{1'b1}}) << (k * NS'(0) + k * int'(SEG));

    if (k == 0) begin : g_head
      assign sa[k]  = bus.a;
      assign sb[k]  = b_eff;
      assign sps[k] = '0;
      assign scy[k] = (bus.sub == MODE_SUB) ? 1'b1 : bus.c_in;
      assign sv[k]  = bus.in_valid;
    end else begin : g_body
      assign sa[k]  = opa_q[k-1];
      assign sb[k]  = opb_q[k-1];
      assign sps[k] = ps_q[k-1];
      assign scy[k] = cy_q[k-1];
      assign sv[k]  = v[k-1];
    end

    add_rca_seg #(.SEG(SEG)) u_seg (
      .a        (sa[k][k*int'(SEG) +: SEG]),
      .b        (sb[k][k*int'(SEG) +: SEG]),
      .c_in     (scy[k]),
      .sum      (seg_sum[k]),
      .c_out    (seg_co[k]),
      .c_msb_in (seg_cm[k])
    );

    // Splice this stage's segment into the completed lower bits carried with the beat.
    assign ps_nxt[k] = (sps[k] & ~MASK) | (WIDTH'(seg_sum[k]) << (k * int'(SEG)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        ps_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (load[k]) begin
          v[k] <= sv[k];
          if (sv[k]) begin
            opa_q[k] <= sa[k];
            opb_q[k] <= sb[k];
            ps_q[k]  <= ps_nxt[k];
            cy_q[k]  <= seg_co[k];
          end
        end
      end
      if (load[NS-1] && sv[NS-1]) ovf_q <= seg_cm[NS-1] ^ seg_co[NS-1];
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = v[NS-1];
  assign bus.sum       = ps_q[NS-1];
  assign bus.c_out     = cy_q[NS-1];
  assign bus.ovf       = ovf_q;

endmodule
